// File: rtl/tff_bank_write_sched.sv
// Round-robin write scheduler that turns absolute-value loads into one-cycle toggle enables for a shared T-FF bank.
// Optional build macro TBANK_VERIFY_EN adds a VERIFY state and a sticky err flag.
module tff_bank_write_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic [WIDTH-1:0]      q_in,
  output logic [WIDTH-1:0]      t_en,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PTR_W = $clog2(NREQ);

`ifdef TBANK_VERIFY_EN
  typedef enum logic [1:0] {IDLE, ARB, TOGGLE, VERIFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARB, TOGGLE} state_t;
`endif

  state_t             state, state_d;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]   owner, owner_d;
  logic [WIDTH-1:0]   cap_data, cap_data_d;
  logic [NREQ-1:0]    req_ready_d;
  logic [WIDTH-1:0]   t_en_d;
  logic               done_d;
  logic               any_valid;
  logic               found_hi;
  logic [PTR_W-1:0]   win, win_hi, win_lo;
  logic [WIDTH-1:0]   sel_data;

  assign any_valid = |req_valid;

  // Descending scan leaves the lowest valid index at/after rr_ptr in win_hi,
  // and the lowest valid index overall in win_lo for the wrap-around case.
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    sel_data = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (PTR_W'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          win_hi   = PTR_W'(i);
        end
        win_lo = PTR_W'(i);
      end
    end
    win = found_hi ? win_hi : win_lo;
    for (int i = 0; i < NREQ; i++) begin
      if (PTR_W'(i) == win) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    owner_d     = owner;
    cap_data_d  = cap_data;
    req_ready_d = '0;
    t_en_d      = '0;
    done_d      = 1'b0;
    case (state)
      IDLE: if (any_valid) state_d = ARB;
      ARB: begin
        if (any_valid) begin
          cap_data_d  = sel_data;
          owner_d     = win;
          req_ready_d = NREQ'(1) << win;
          rr_ptr_d    = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
          // Registered here so the pulse lands exactly in the TOGGLE cycle;
          // sel_data is the value being captured into cap_data.
          t_en_d      = sel_data ^ q_in;
          state_d     = TOGGLE;
        end else begin
          state_d = IDLE;
        end
      end
`ifdef TBANK_VERIFY_EN
      TOGGLE: state_d = VERIFY;
      VERIFY: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
`else
      TOGGLE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cap_data  <= '0;
      req_ready <= '0;
      t_en      <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      owner     <= owner_d;
      cap_data  <= cap_data_d;
      req_ready <= req_ready_d;
      t_en      <= t_en_d;
      done      <= done_d;
    end
  end

`ifdef TBANK_VERIFY_EN
  logic err_q;

  // Sticky: once the bank failed to settle, only reset clears the flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state == VERIFY && q_in != cap_data) begin
      err_q <= 1'b1;
    end
  end

  assign err   = err_q;
  assign grant = (state == TOGGLE || state == VERIFY) ? (NREQ'(1) << owner) : '0;
`else
  assign err   = 1'b0;
  assign grant = (state == TOGGLE) ? (NREQ'(1) << owner) : '0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tff_bank_write_sched.sv
// Directed bench for tff_bank_write_sched with a behavioural T-FF bank and a queue of expected accepts.
// Build with or without TBANK_VERIFY_EN to match the design.
module tb_tff_bank_write_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      q_in;
  logic [WIDTH-1:0]      t_en;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic                  err;

  logic [WIDTH-1:0]      q_bank;
  logic                  q_load;
  logic [WIDTH-1:0]      q_load_val;
  logic                  bank_follow;
  logic                  exp_err;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  tff_bank_write_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q_in      (q_in),
    .t_en      (t_en),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Bank model: toggles on t_en unless told to ignore it or to load a value.
  always @(posedge clk) begin
    if (q_load) q_bank <= q_load_val;
    else if (bank_follow) q_bank <= q_bank ^ t_en;
  end
  assign q_in = q_bank;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [WIDTH-1:0] d);
    req_data[idx*WIDTH +: WIDTH] = d;
    req_valid = req_valid | (NREQ'(1) << idx);
    sb.push_back('{idx, d});
  endtask

  task automatic set_bank(input logic [WIDTH-1:0] v);
    q_load     = 1'b1;
    q_load_val = v;
    step();
    q_load     = 1'b0;
  endtask

  // Waits for the accept, checks it against the oldest expectation, then
  // follows the write to its done pulse (or resets it mid-write).
  task automatic do_txn(input string tag, input int exp_wait, input bit hold, input bit abort);
    int               waited;
    exp_t             e;
    logic [NREQ-1:0]  oh;
    logic [WIDTH-1:0] exp_ten;
    waited = 0;
    while (req_ready == '0 && waited < 20) begin
      step();
      waited++;
    end
    check($sformatf("%s wait", tag), waited, exp_wait);
    if (sb.size() == 0) begin
      check($sformatf("%s sb_empty", tag), 1, 0);
      return;
    end
    e       = sb.pop_front();
    oh      = NREQ'(1) << e.idx;
    exp_ten = e.data ^ q_bank;
    check($sformatf("%s req_ready", tag), req_ready, oh);
    check($sformatf("%s grant", tag), grant, oh);
    check($sformatf("%s t_en", tag), t_en, exp_ten);
    check($sformatf("%s busy", tag), busy, 1);
    if (!hold) req_valid = req_valid & ~oh;
    if (abort) begin
      rst = 1'b0;
      step();
      check($sformatf("%s abort t_en", tag), t_en, 0);
      check($sformatf("%s abort grant", tag), grant, 0);
      check($sformatf("%s abort busy", tag), busy, 0);
      check($sformatf("%s abort done", tag), done, 0);
      check($sformatf("%s abort ready", tag), req_ready, 0);
      rst = 1'b1;
      return;
    end
    step();
`ifdef TBANK_VERIFY_EN
    check($sformatf("%s verify busy", tag), busy, 1);
    check($sformatf("%s verify done", tag), done, 0);
    check($sformatf("%s verify t_en", tag), t_en, 0);
    step();
`endif
    check($sformatf("%s done", tag), done, 1);
    check($sformatf("%s t_en off", tag), t_en, 0);
    check($sformatf("%s err", tag), err, exp_err);
  endtask

  initial begin
    rst         = 1'b0;
    req_valid   = '1;
    req_data    = {8'h88, 8'h44, 8'h22, 8'h11};
    q_load      = 1'b1;
    q_load_val  = 8'h00;
    bank_follow = 1'b1;
    exp_err     = 1'b0;

    // Reset held two cycles with every requester pending.
    step();
    step();
    q_load = 1'b0;
    check("rst req_ready", req_ready, 0);
    check("rst t_en", t_en, 0);
    check("rst grant", grant, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);

    // Release reset straight into a continuous round-robin run.
    rst = 1'b1;
    sb.push_back('{0, 8'h11});
    sb.push_back('{1, 8'h22});
    sb.push_back('{2, 8'h44});
    sb.push_back('{3, 8'h88});
    sb.push_back('{0, 8'h11});
    do_txn("rr0", 2, 1'b1, 1'b0);
    do_txn("rr1", 2, 1'b1, 1'b0);
    do_txn("rr2", 2, 1'b1, 1'b0);
    do_txn("rr3", 2, 1'b1, 1'b0);
    do_txn("rr0_wrap", 2, 1'b1, 1'b0);
    req_valid = '0;
    step();
    step();
    check("idle busy", busy, 0);
    check("idle ready", req_ready, 0);

    // Single write from a cleared bank.
    set_bank(8'h00);
    push(0, 8'hA5);
    do_txn("single", 2, 1'b0, 1'b0);
    step();
    check("single bank", q_bank, 8'hA5);

    // Writing the value already held produces no toggles.
    set_bank(8'h3C);
    push(2, 8'h3C);
    do_txn("nochg", 2, 1'b0, 1'b0);

`ifdef TBANK_VERIFY_EN
    // Bank ignores t_en, so verify must flag it; err then sticks.
    bank_follow = 1'b0;
    set_bank(8'h00);
    push(3, 8'hFF);
    exp_err = 1'b1;
    do_txn("vfail", 2, 1'b0, 1'b0);
    bank_follow = 1'b1;
    push(1, 8'h5A);
    do_txn("after_fail", 2, 1'b0, 1'b0);
`endif

    // Reset in the TOGGLE cycle; requester keeps valid and is served again.
    set_bank(8'h0F);
    push(1, 8'h77);
    do_txn("abort", 2, 1'b1, 1'b1);
    exp_err = 1'b0;
    check("abort err", err, 0);
    check("abort bank", q_bank, 8'h77);
    push(1, 8'hC3);
    do_txn("reserve", 2, 1'b0, 1'b0);

    step();
    check("end busy", busy, 0);
    check("sb drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
